// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// master drives the request side (start, operands, carry-in),
// slave drives status and result (busy, done, sum, cout, overflow).
interface serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: start sampled in IDLE -> done pulse WIDTH+1 cycles later; one op per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy or done, results hold until the next op.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // Single full-adder cell working on the current LSBs and the carry flop.
    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands in position 0.
    assign psum_d   = (psum_q >> 1) | ({{(WIDTH - 1){1'b0}}, fa_s} << (WIDTH - 1));

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and busy/done decode.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, serial shift datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            psum_q <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q <= bus.a;
                        b_sh_q <= bus.b;
                        c_q    <= bus.cin;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    psum_q <= psum_d;
                    c_q    <= fa_c;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // On the MSB cycle c_q is the carry into the MSB.
                        sum_q  <= psum_d;
                        cout_q <= fa_c;
                        ovf_q  <= c_q ^ fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=4 (directed + streaming) and WIDTH=8 (random).
// Reference: plain integer addition; overflow from operand/result sign bits.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    serial_adder_if #(.WIDTH(4)) if4 ();
    serial_adder_if #(.WIDTH(8)) if8 ();

    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full WIDTH=4 operation: issue, check latency, then result against the model.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
        logic [4:0] full;
        logic       ovf;
        int         n;
        full = {1'b0, a} + {1'b0, b} + {4'b0, c};
        ovf  = (a[3] == b[3]) && (full[3] != a[3]);
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b; if4.cin = c;
        @(negedge clk);
        if4.start = 1'b0; if4.a = 4'($urandom); if4.b = 4'($urandom); if4.cin = 1'($urandom);
        chk({tag, "_busy"}, 64'(if4.busy), 64'd1);
        n = 1;
        while (!if4.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd5);
        chk({tag, "_sum"}, 64'(if4.sum), 64'(full[3:0]));
        chk({tag, "_cout"}, 64'(if4.cout), 64'(full[4]));
        chk({tag, "_ovf"}, 64'(if4.overflow), 64'(ovf));
        chk({tag, "_busy_at_done"}, 64'(if4.busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 64'(if4.done), 64'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] full;
        logic       ovf;
        int         n;
        full = {1'b0, a} + {1'b0, b} + {8'b0, c};
        ovf  = (a[7] == b[7]) && (full[7] != a[7]);
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
        @(negedge clk);
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
        n = 1;
        while (!if8.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("w8_lat", 64'(n), 64'd9);
        chk("w8_sum", 64'(if8.sum), 64'(full[7:0]));
        chk("w8_cout", 64'(if8.cout), 64'(full[8]));
        chk("w8_ovf", 64'(if8.overflow), 64'(ovf));
    endtask

    logic [3:0] sa [0:40];
    logic [3:0] sb [0:40];
    logic       sc [0:40];

    initial begin
        logic [3:0] hs;
        logic       hc;
        logic       ho;
        int         dones;
        logic [4:0] full;
        logic       ovf;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        #1;
        chk("rst_busy", 64'(if4.busy), 64'd0);
        chk("rst_done", 64'(if4.done), 64'd0);
        chk("rst_sum", 64'(if4.sum), 64'd0);
        chk("rst_cout", 64'(if4.cout), 64'd0);
        chk("rst_ovf", 64'(if4.overflow), 64'd0);
        chk("rst_sum8", 64'(if8.sum), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors from the test plan.
        op4(4'b0101, 4'b0011, 1'b0, "v1");
        op4(4'b1111, 4'b0001, 1'b0, "v2");
        op4(4'b1001, 4'b0110, 1'b1, "v3");
        op4(4'b1000, 4'b1000, 1'b0, "v4");

        // Outputs hold for 10 idle cycles while inputs wander.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if4.a = 4'($urandom); if4.b = 4'($urandom); if4.cin = 1'($urandom);
            chk("hold_sum", 64'(if4.sum), 64'd0);
            chk("hold_cout", 64'(if4.cout), 64'd1);
            chk("hold_ovf", 64'(if4.overflow), 64'd1);
        end

        // start pulsed in RUN cycle 2 with different operands must be ignored.
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'b0110; if4.b = 4'b0111; if4.cin = 1'b0;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'b0001; if4.b = 4'b0001; if4.cin = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        dones = 0;
        hs = 'x; hc = 1'bx; ho = 1'bx;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if4.done) begin
                dones++;
                hs = if4.sum; hc = if4.cout; ho = if4.overflow;
            end
        end
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_sum", 64'(hs), 64'd13);
        chk("ign_cout", 64'(hc), 64'd0);
        chk("ign_ovf", 64'(ho), 64'd1);

        // Reset asynchronously in RUN cycle 2.
        @(negedge clk);
        if4.start = 1'b1; if4.a = 4'b0011; if4.b = 4'b0100; if4.cin = 1'b0;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(if4.busy), 64'd0);
        chk("mid_rst_done", 64'(if4.done), 64'd0);
        chk("mid_rst_sum", 64'(if4.sum), 64'd0);
        chk("mid_rst_cout", 64'(if4.cout), 64'd0);
        chk("mid_rst_ovf", 64'(if4.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        op4(4'b0110, 4'b1011, 1'b1, "post_rst");
        @(negedge clk);

        // start held high, fresh random operands every cycle: accept every 6 cycles.
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            chk("strm_done", 64'(if4.done), 64'((k % 6 == 5) && (k <= 29)));
            chk("strm_excl", 64'(if4.busy & if4.done), 64'd0);
            if (k % 6 == 5 && k <= 29) begin
                full = {1'b0, sa[k-5]} + {1'b0, sb[k-5]} + {4'b0, sc[k-5]};
                ovf  = (sa[k-5][3] == sb[k-5][3]) && (full[3] != sa[k-5][3]);
                chk("strm_sum", 64'(if4.sum), 64'(full[3:0]));
                chk("strm_cout", 64'(if4.cout), 64'(full[4]));
                chk("strm_ovf", 64'(if4.overflow), 64'(ovf));
            end
            sa[k] = 4'($urandom); sb[k] = 4'($urandom); sc[k] = 1'($urandom);
            if4.start = (k < 30);
            if4.a = sa[k]; if4.b = sb[k]; if4.cin = sc[k];
        end
        if4.start = 1'b0;

        // 200 random vectors at WIDTH=8.
        for (int i = 0; i < 200; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
